// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and data_memory sides of the data-memory arbiter.
// master = requesters + memory (environment), slave = the arbiter itself.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_width;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [2:0]  dbg_width;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output core_req, core_we, core_width,
    output core_addr, core_wdata,
    input  core_gnt, core_stall,
    input  core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_width,
    output dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_read, mem_write, mem_width,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_width,
    input  core_addr, core_wdata,
    output core_gnt, core_stall,
    output core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_width,
    input  dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_read, mem_write, mem_width,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single data_memory port.
// Core has priority; debug is forced through after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int CW =
    (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);

  logic [CW-1:0] r_wait_cnt;
  logic          r_core_rvalid;
  logic [31:0]   r_core_rdata;
  logic          r_dbg_rvalid;
  logic [31:0]   r_dbg_rdata;

  logic          w_dbg_win;
  logic          w_core_win;
  logic          w_any;
  logic          w_we;
  logic [2:0]    w_width;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;

  // Grants are gated by rst_n so nothing reaches memory in reset.
  always_comb begin
    w_dbg_win  = rst_n & bus.dbg_req &
                 (~bus.core_req | (r_wait_cnt == MAXC));
    w_core_win = rst_n & bus.core_req & ~w_dbg_win;
    w_any   = 1'b0;
    w_we    = 1'b0;
    w_width = 3'd0;
    w_addr  = 32'd0;
    w_wdata = 32'd0;
    unique case (1'b1)
      w_dbg_win: begin
        w_any   = 1'b1;
        w_we    = bus.dbg_we;
        w_width = bus.dbg_width;
        w_addr  = bus.dbg_addr;
        w_wdata = bus.dbg_wdata;
      end
      w_core_win: begin
        w_any   = 1'b1;
        w_we    = bus.core_we;
        w_width = bus.core_width;
        w_addr  = bus.core_addr;
        w_wdata = bus.core_wdata;
      end
      default: ;
    endcase
  end

  assign bus.core_gnt   = w_core_win;
  assign bus.core_stall = bus.core_req & ~w_core_win;
  assign bus.dbg_gnt    = w_dbg_win;

  assign bus.mem_read  = w_any & ~w_we;
  assign bus.mem_write = w_any & w_we;
  assign bus.mem_width = w_width;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  assign bus.core_rvalid = r_core_rvalid;
  assign bus.core_rdata  = r_core_rdata;
  assign bus.dbg_rvalid  = r_dbg_rvalid;
  assign bus.dbg_rdata   = r_dbg_rdata;

  // A dropped debug request forfeits its accumulated wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (bus.dbg_req & ~w_dbg_win) begin
      if (r_wait_cnt != MAXC)
        r_wait_cnt <= r_wait_cnt + CW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rvalid <= 1'b0;
      r_core_rdata  <= 32'd0;
      r_dbg_rvalid  <= 1'b0;
      r_dbg_rdata   <= 32'd0;
    end else begin
      r_core_rvalid <= w_core_win & ~bus.core_we;
      r_dbg_rvalid  <= w_dbg_win & ~bus.dbg_we;
      if (w_core_win & ~bus.core_we)
        r_core_rdata <= bus.mem_rdata;
      if (w_dbg_win & ~bus.dbg_we)
        r_dbg_rdata <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table vectors, directed corners and
// random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus0 ();

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  dmem_arbiter #(.MAX_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  bit [31:0] tbmem [256];
  assign bus.mem_rdata = tbmem[bus.mem_addr[9:2]];
  always @(posedge clk)
    if (bus.mem_write)
      tbmem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  assign bus0.mem_rdata = bus0.mem_addr ^ 32'hA5A5_0000;

  int checks = 0;
  int errors = 0;

  int        denied = 0;
  bit        erv_c = 0, erv_d = 0;
  bit [31:0] erd_c = 0, erd_d = 0;
  bit [31:0] ref_mem [256];

  typedef struct {
    bit        cr, cw;
    logic [31:0] ca, cd;
    bit        dr, dw;
    logic [31:0] da, dd;
    bit        ecg, edg;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t mk(
    input bit cr, cw, input logic [31:0] ca, cd,
    input bit dr, dw, input logic [31:0] da, dd,
    input bit ecg, edg);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive, check against the model, advance the model.
  task automatic cyc(
    input bit cr, cw, input logic [31:0] ca, cd,
    input bit dr, dw, input logic [31:0] da, dd,
    output bit cg, dg);
    bit ecg, edg, any, wwe;
    logic [31:0] wa, wd;
    logic [2:0]  ww;
    @(negedge clk);
    bus.core_req = cr; bus.core_we = cw;
    bus.core_addr = ca; bus.core_wdata = cd;
    bus.core_width = 3'b010;
    bus.dbg_req = dr; bus.dbg_we = dw;
    bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.dbg_width = 3'b001;
    #1;
    edg = dr && (!cr || denied == MW);
    ecg = cr && !edg;
    any = ecg || edg;
    wwe = edg ? dw : (ecg ? cw : 1'b0);
    wa  = edg ? da : (ecg ? ca : 32'd0);
    wd  = edg ? dd : (ecg ? cd : 32'd0);
    ww  = edg ? 3'b001 : (ecg ? 3'b010 : 3'b000);
    chk("core_gnt", 32'(bus.core_gnt), 32'(ecg));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(edg));
    chk("core_stall", 32'(bus.core_stall), 32'(cr && !ecg));
    chk("mem_read", 32'(bus.mem_read), 32'(any && !wwe));
    chk("mem_write", 32'(bus.mem_write), 32'(any && wwe));
    chk("mem_addr", bus.mem_addr, wa);
    chk("mem_wdata", bus.mem_wdata, wd);
    chk("mem_width", 32'(bus.mem_width), 32'(ww));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(erv_c));
    chk("core_rdata", bus.core_rdata, erd_c);
    chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(erv_d));
    chk("dbg_rdata", bus.dbg_rdata, erd_d);
    erv_c = ecg && !cw;
    erv_d = edg && !dw;
    if (erv_c) erd_c = ref_mem[ca[9:2]];
    if (erv_d) erd_d = ref_mem[da[9:2]];
    if (any && wwe) ref_mem[wa[9:2]] = wd;
    if (dr && !edg) denied = (denied < MW) ? denied + 1 : MW;
    else denied = 0;
    cg = ecg;
    dg = edg;
  endtask

  bit gc, gd;
  bit hc = 0, hd = 0;
  bit rcr, rcw, rdr, rdw;
  logic [31:0] rca, rcd, rda, rdd;

  initial begin
    vt[0]  = mk(0,0,0,0,     1,1,'h40,'h12345678, 0,1);
    vt[1]  = mk(0,0,0,0,     1,0,'h40,0,          0,1);
    vt[2]  = mk(0,0,0,0,     1,1,'h10,'hDEADBEEF, 0,1);
    vt[3]  = mk(1,0,'h10,0,  0,0,0,0,             1,0);
    vt[4]  = mk(0,0,0,0,     0,0,0,0,             0,0);
    for (int i = 5; i < 15; i++)
      vt[i] = mk(1,0,'h10,0, 1,0,'h40,0,
                 1, (i == 9 || i == 14) ? 1'b0 : 1'b0);
    vt[9]  = mk(1,0,'h10,0,  1,0,'h40,0,          0,1);
    vt[14] = mk(1,0,'h10,0,  1,0,'h40,0,          0,1);
    vt[15] = mk(0,0,0,0,     0,0,0,0,             0,0);
    for (int i = 16; i < 24; i++)
      vt[i] = mk(1,1,'h20,i, 1,0,'h40,0,          1,0);
    vt[19] = mk(1,1,'h20,19, 0,0,0,0,             1,0);
    vt[24] = mk(1,1,'h20,24, 1,0,'h40,0,          0,1);
    vt[25] = mk(0,0,0,0,     0,0,0,0,             0,0);

    bus.core_req = 0; bus.core_we = 0; bus.core_width = 0;
    bus.core_addr = 0; bus.core_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_width = 0;
    bus.dbg_addr = 0; bus.dbg_wdata = 0;
    bus0.core_req = 0; bus0.core_we = 0; bus0.core_width = 0;
    bus0.core_addr = 0; bus0.core_wdata = 0;
    bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_width = 0;
    bus0.dbg_addr = 0; bus0.dbg_wdata = 0;

    // Reset: gnt and memory strobes forced low even with requests.
    #2;
    bus.core_req = 1; bus.dbg_req = 1;
    #1;
    chk("rst core_gnt", 32'(bus.core_gnt), 0);
    chk("rst dbg_gnt", 32'(bus.dbg_gnt), 0);
    chk("rst mem_read", 32'(bus.mem_read), 0);
    chk("rst mem_write", 32'(bus.mem_write), 0);
    chk("rst core_rvalid", 32'(bus.core_rvalid), 0);
    chk("rst dbg_rvalid", 32'(bus.dbg_rvalid), 0);
    chk("rst core_rdata", bus.core_rdata, 0);
    chk("rst dbg_rdata", bus.dbg_rdata, 0);
    @(negedge clk);
    bus.core_req = 0; bus.dbg_req = 0;
    rst_n = 1;

    for (int i = 0; i < $size(vt); i++) begin
      cyc(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
          vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd, gc, gd);
      chk($sformatf("vec%0d core_gnt", i),
          32'(bus.core_gnt), 32'(vt[i].ecg));
      chk($sformatf("vec%0d dbg_gnt", i),
          32'(bus.dbg_gnt), 32'(vt[i].edg));
      if (i == 2) chk("dbg readback", bus.dbg_rdata, 'h12345678);
      if (i == 4) chk("core load", bus.core_rdata, 'hDEADBEEF);
    end

    // Reset while a load response is outstanding.
    cyc(1,0,'h10,0, 0,0,0,0, gc, gd);
    chk("rl gnt", 32'(bus.core_gnt), 1);
    @(posedge clk);
    #2;
    chk("rl rvalid pre", 32'(bus.core_rvalid), 1);
    rst_n = 0;
    #1;
    chk("rl rvalid", 32'(bus.core_rvalid), 0);
    chk("rl rdata", bus.core_rdata, 0);
    chk("rl gnt forced", 32'(bus.core_gnt), 0);
    chk("rl mem_read", 32'(bus.mem_read), 0);
    denied = 0; erv_c = 0; erv_d = 0; erd_c = 0; erd_d = 0;
    @(negedge clk);
    bus.core_req = 0; bus.dbg_req = 0;
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      cyc(1,0,'h44,0, 1,0,'h48,0, gc, gd);
      chk($sformatf("post-rst dbg_gnt %0d", k),
          32'(bus.dbg_gnt), 32'(k == 4));
    end

    // Random traffic; requesters hold until granted.
    for (int n = 0; n < 600; n++) begin
      if (!hc) begin
        rcr = ($urandom_range(0, 3) != 0);
        rcw = $urandom_range(0, 1) != 0;
        rca = 32'($urandom_range(0, 15)) << 2;
        rcd = $urandom;
      end
      if (!hd) begin
        rdr = ($urandom_range(0, 2) == 0);
        rdw = $urandom_range(0, 1) != 0;
        rda = 32'($urandom_range(0, 15)) << 2;
        rdd = $urandom;
      end
      cyc(rcr, rcw, rca, rcd, rdr, rdw, rda, rdd, gc, gd);
      hc = rcr && !gc;
      hd = rdr && !gd;
    end

    // MAX_WAIT = 0: debug has strict priority.
    @(negedge clk);
    bus.core_req = 0; bus.dbg_req = 0;
    bus0.core_req = 1; bus0.core_addr = 'h100;
    bus0.dbg_req = 1; bus0.dbg_addr = 'h200;
    bus0.dbg_width = 3'b010;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("mw0 dbg_gnt", 32'(bus0.dbg_gnt), 1);
      chk("mw0 core_gnt", 32'(bus0.core_gnt), 0);
      chk("mw0 core_stall", 32'(bus0.core_stall), 1);
      chk("mw0 mem_addr", bus0.mem_addr, 'h200);
      if (k > 0) begin
        chk("mw0 dbg_rvalid", 32'(bus0.dbg_rvalid), 1);
        chk("mw0 dbg_rdata", bus0.dbg_rdata, 'hA5A5_0200);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
